// File: rtl/pipe_pkg.sv
// Shared types for the pipe_*_skid_stage family of pipeline boundary blocks.
package pipe_pkg;

  // Occupancy of a 1-entry-plus-skid pipeline boundary.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } mw_state_t;

  // Default datapath widths of the core.
  localparam int PIPE_DW = 32;
  localparam int PIPE_RW = 5;

  // MEM->WB payload at the default widths. Stages built with other widths
  // declare the same field order locally so the packing stays identical.
  typedef struct packed {
    logic               wreg;
    logic               m2reg;
    logic [PIPE_DW-1:0] mo;
    logic [PIPE_DW-1:0] alu;
    logic [PIPE_RW-1:0] rn;
  } mw_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready skid buffer: one main entry plus one skid entry, so the
// upstream ready depends only on local state and never on downstream ready.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  mw_state_t    state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         retire;

  // Handshake flags and state-decoded outputs; no path from out_ready to in_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

  // Occupancy FSM; flush wins over any same-cycle accept or retire.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && retire) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q <= in_data;
            state  <= TWO;
          end else if (retire) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (retire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_mw_skid_stage.sv
// MEM->WB pipeline boundary: carries write-back control and data, squashes r0
// writes at entry, and presents the selected write-back value for forwarding.
module pipe_mw_skid_stage
  import pipe_pkg::*;
#(
  parameter int DW   = PIPE_DW,
  parameter int RW   = PIPE_RW,
  parameter bit SKID = 1'b1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_wreg,
  input  logic          in_m2reg,
  input  logic [DW-1:0] in_mo,
  input  logic [DW-1:0] in_alu,
  input  logic [RW-1:0] in_rn,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_wreg,
  output logic          out_m2reg,
  output logic [DW-1:0] out_mo,
  output logic [DW-1:0] out_alu,
  output logic [RW-1:0] out_rn,
  output logic [DW-1:0] fwd_wdata
);

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic [DW-1:0] mo;
    logic [DW-1:0] alu;
    logic [RW-1:0] rn;
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t in_pl;
  payload_t out_pl;

  // Pack the incoming instruction; a write to r0 is dropped here once.
  always_comb begin
    in_pl       = '0;
    in_pl.wreg  = in_wreg & (in_rn != '0);
    in_pl.m2reg = in_m2reg;
    in_pl.mo    = in_mo;
    in_pl.alu   = in_alu;
    in_pl.rn    = in_rn;
  end

  if (SKID) begin : g_skid
    pipe_skid_buf #(.W(PW)) u_buf (
      .clk       (clk),
      .clrn      (clrn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_pl)
    );
  end else begin : g_plain
    logic     valid_q;
    payload_t data_q;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_pl    = data_q;

    // Single stall register: load whenever the slot is free or being retired.
    always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (in_ready) begin
        valid_q <= in_valid;
        if (in_valid) data_q <= in_pl;
      end
    end
  end

  // Unpack held entry; wreg is gated so a flushed or empty stage never writes.
  assign out_wreg  = out_pl.wreg & out_valid;
  assign out_m2reg = out_pl.m2reg;
  assign out_mo    = out_pl.mo;
  assign out_alu   = out_pl.alu;
  assign out_rn    = out_pl.rn;
  assign fwd_wdata = out_pl.m2reg ? out_pl.mo : out_pl.alu;

endmodule

// File: tb/tb_pipe_mw_skid_stage.sv
// Directed bench for pipe_mw_skid_stage: index 1 is the SKID=1 instance,
// index 0 the SKID=0 instance; both share clock and reset.
module tb_pipe_mw_skid_stage;

  logic        clk;
  logic        clrn;
  logic        flush     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        in_wreg   [2];
  logic        in_m2reg  [2];
  logic [31:0] in_mo     [2];
  logic [31:0] in_alu    [2];
  logic [4:0]  in_rn     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        out_wreg  [2];
  logic        out_m2reg [2];
  logic [31:0] out_mo    [2];
  logic [31:0] out_alu   [2];
  logic [4:0]  out_rn    [2];
  logic [31:0] fwd_wdata [2];

  int n_tests = 0;
  int n_fail  = 0;

  pipe_mw_skid_stage #(.DW(32), .RW(5), .SKID(1'b1)) dut_skid (
    .clk(clk), .clrn(clrn), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_wreg(in_wreg[1]), .in_m2reg(in_m2reg[1]),
    .in_mo(in_mo[1]), .in_alu(in_alu[1]), .in_rn(in_rn[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_wreg(out_wreg[1]), .out_m2reg(out_m2reg[1]),
    .out_mo(out_mo[1]), .out_alu(out_alu[1]), .out_rn(out_rn[1]),
    .fwd_wdata(fwd_wdata[1])
  );

  pipe_mw_skid_stage #(.DW(32), .RW(5), .SKID(1'b0)) dut_plain (
    .clk(clk), .clrn(clrn), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_wreg(in_wreg[0]), .in_m2reg(in_m2reg[0]),
    .in_mo(in_mo[0]), .in_alu(in_alu[0]), .in_rn(in_rn[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_wreg(out_wreg[0]), .out_m2reg(out_m2reg[0]),
    .out_mo(out_mo[0]), .out_alu(out_alu[0]), .out_rn(out_rn[0]),
    .fwd_wdata(fwd_wdata[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic wreg, input logic m2reg,
                       input logic [31:0] mo, input logic [31:0] alu, input logic [4:0] rn);
    in_valid[k] = v;
    in_wreg[k]  = wreg;
    in_m2reg[k] = m2reg;
    in_mo[k]    = mo;
    in_alu[k]   = alu;
    in_rn[k]    = rn;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // Back-to-back traffic with WB always ready.
  task automatic t_stream(input int k);
    string s;
    out_ready[k] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s = $sformatf("k%0d stream%0d", k, i);
      drive(k, 1'b1, 1'b1, 1'b0, 32'h0, 32'h100 + i, i[4:0]);
      check({s, " in_ready"}, {31'b0, in_ready[k]}, 32'd1);
      tick();
      check({s, " out_valid"}, {31'b0, out_valid[k]}, 32'd1);
      check({s, " out_rn"}, {27'b0, out_rn[k]}, i);
      check({s, " out_alu"}, out_alu[k], 32'h100 + i);
      check({s, " out_wreg"}, {31'b0, out_wreg[k]}, 32'd1);
    end
    idle(k);
    tick();
    check($sformatf("k%0d stream drain", k), {31'b0, out_valid[k]}, 32'd0);
  endtask

  // WB stalls with two instructions offered.
  task automatic t_stall(input int k);
    out_ready[k] = 1'b0;
    drive(k, 1'b1, 1'b1, 1'b0, 32'h0, 32'hA, 5'd3);
    tick();
    check($sformatf("k%0d stall first rn", k), {27'b0, out_rn[k]}, 32'd3);
    if (k == 1) begin
      check("k1 stall ready after 1", {31'b0, in_ready[k]}, 32'd1);
      drive(k, 1'b1, 1'b1, 1'b0, 32'h0, 32'hB, 5'd4);
      tick();
      check("k1 stall ready after 2", {31'b0, in_ready[k]}, 32'd0);
      idle(k);
    end else begin
      check("k0 stall ready after 1", {31'b0, in_ready[k]}, 32'd0);
      drive(k, 1'b1, 1'b1, 1'b0, 32'h0, 32'hB, 5'd4);
      tick();
    end
    check($sformatf("k%0d stall hold rn", k), {27'b0, out_rn[k]}, 32'd3);
    check($sformatf("k%0d stall hold alu", k), out_alu[k], 32'hA);
    check($sformatf("k%0d stall hold valid", k), {31'b0, out_valid[k]}, 32'd1);
    out_ready[k] = 1'b1;
    tick();
    idle(k);
    check($sformatf("k%0d stall second rn", k), {27'b0, out_rn[k]}, 32'd4);
    check($sformatf("k%0d stall second alu", k), out_alu[k], 32'hB);
    check($sformatf("k%0d stall ready back", k), {31'b0, in_ready[k]}, 32'd1);
    tick();
    check($sformatf("k%0d stall drained", k), {31'b0, out_valid[k]}, 32'd0);
  endtask

  // Write to r0 is carried but never writes.
  task automatic t_r0(input int k);
    out_ready[k] = 1'b1;
    drive(k, 1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD, 5'd0);
    tick();
    idle(k);
    check($sformatf("k%0d r0 valid", k), {31'b0, out_valid[k]}, 32'd1);
    check($sformatf("k%0d r0 wreg", k), {31'b0, out_wreg[k]}, 32'd0);
    check($sformatf("k%0d r0 alu", k), out_alu[k], 32'hDEAD);
    tick();
  endtask

  // Forwarding mux selects memory or ALU data.
  task automatic t_fwd(input int k);
    out_ready[k] = 1'b1;
    drive(k, 1'b1, 1'b1, 1'b1, 32'h1234, 32'h5678, 5'd2);
    tick();
    check($sformatf("k%0d fwd mem", k), fwd_wdata[k], 32'h1234);
    drive(k, 1'b1, 1'b1, 1'b0, 32'h1234, 32'h5678, 5'd2);
    tick();
    idle(k);
    check($sformatf("k%0d fwd alu", k), fwd_wdata[k], 32'h5678);
    tick();
  endtask

  // Flush in TWO and in ONE with an offered instruction; it must vanish.
  task automatic t_flush();
    out_ready[1] = 1'b0;
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd5);
    tick();
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h66, 5'd6);
    tick();
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd7);
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    idle(1);
    check("flush two valid", {31'b0, out_valid[1]}, 32'd0);
    check("flush two wreg", {31'b0, out_wreg[1]}, 32'd0);
    check("flush two ready", {31'b0, in_ready[1]}, 32'd1);
    tick();
    check("flush two stays empty", {31'b0, out_valid[1]}, 32'd0);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd5);
    tick();
    check("flush one loaded", {31'b0, out_valid[1]}, 32'd1);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h99, 5'd9);
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    idle(1);
    check("flush one valid", {31'b0, out_valid[1]}, 32'd0);
    check("flush one wreg", {31'b0, out_wreg[1]}, 32'd0);
    out_ready[1] = 1'b1;
    tick();
    check("flush one word gone", {31'b0, out_valid[1]}, 32'd0);
  endtask

  // Asynchronous reset while the skid instance holds two entries.
  task automatic t_reset_mid();
    out_ready[1] = 1'b0;
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h55, 5'd5);
    tick();
    drive(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h66, 5'd6);
    tick();
    idle(1);
    check("rst pre full", {31'b0, in_ready[1]}, 32'd0);
    clrn = 1'b1;
    #1;
    check("rst async valid", {31'b0, out_valid[1]}, 32'd0);
    check("rst async wreg", {31'b0, out_wreg[1]}, 32'd0);
    check("rst async alu", out_alu[1], 32'h0);
    check("rst async rn", {27'b0, out_rn[1]}, 32'd0);
    tick();
    clrn = 1'b0;
    #1;
    check("rst release ready", {31'b0, in_ready[1]}, 32'd1);
    out_ready[1] = 1'b1;
    tick();
    check("rst nothing left", {31'b0, out_valid[1]}, 32'd0);
  endtask

  initial begin
    clrn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      flush[k]     = 1'b0;
      out_ready[k] = 1'b0;
      idle(k);
    end
    tick();
    check("reset valid k1", {31'b0, out_valid[1]}, 32'd0);
    check("reset valid k0", {31'b0, out_valid[0]}, 32'd0);
    check("reset alu k1", out_alu[1], 32'h0);
    check("reset fwd k0", fwd_wdata[0], 32'h0);
    clrn = 1'b0;
    #1;
    check("reset ready k1", {31'b0, in_ready[1]}, 32'd1);
    check("reset ready k0", {31'b0, in_ready[0]}, 32'd1);

    for (int k = 1; k >= 0; k--) begin
      t_stream(k);
      t_stall(k);
      t_r0(k);
      t_fwd(k);
    end
    t_flush();
    t_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
